// File: rtl/ace_ccu_excl_pkg.sv
// Shared types and constants for the CCU exclusive-access requester.
package ace_ccu_excl_pkg;

    typedef enum logic {
        EXCL_LOAD  = 1'b0,
        EXCL_STORE = 1'b1
    } excl_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } excl_state_e;

    localparam int unsigned StatWidth = 16;

    function automatic logic [StatWidth-1:0] sat_inc(input logic [StatWidth-1:0] val);
        if (val == {StatWidth{1'b1}}) begin
            sat_inc = val;
        end else begin
            sat_inc = val + {{(StatWidth-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/ace_ccu_excl_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo NumMst.
module ace_ccu_excl_rr_arb #(
    parameter int unsigned NumMst   = 4,
    parameter int unsigned IdxWidth = (NumMst > 1) ? $clog2(NumMst) : 1
) (
    input  logic [NumMst-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumMst-1:0]   gnt,
    output logic [IdxWidth-1:0] gnt_idx,
    output logic                gnt_any
);

    // Scan candidates in pointer order and keep the first one that is requesting.
    always_comb begin
        int unsigned cand;
        logic [IdxWidth-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        for (int unsigned k = 0; k < NumMst; k++) begin
            cand     = (32'(ptr) + k) % NumMst;
            cand_idx = IdxWidth'(cand);
            if (!gnt_any && req[cand_idx]) begin
                gnt_any       = 1'b1;
                gnt_idx       = cand_idx;
                gnt[cand_idx] = 1'b1;
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

endmodule

// File: rtl/ace_ccu_excl_requester.sv
// Exclusive-access requester: arbitrates NumMst masters onto the exclusive monitor, one at a time.
// Define ACE_CCU_EXCL_STATS_EN to add saturating store-verdict counters.
module ace_ccu_excl_requester
    import ace_ccu_excl_pkg::*;
#(
    parameter int unsigned NumMst     = 4,
    parameter int unsigned AmIdxWidth = 4,
    parameter type         mst_idx_t  = logic [NumMst-1:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumMst-1:0]            req_valid_i,
    output logic [NumMst-1:0]            req_ready_o,
    input  logic [NumMst-1:0]            req_store_i,
    input  logic [NumMst*AmIdxWidth-1:0] req_addr_i,
    output logic [NumMst-1:0]            resp_valid_o,
    input  logic [NumMst-1:0]            resp_ready_i,
    output logic                         resp_exokay_o,
    output logic                         am_ex_load_o,
    output logic                         am_ex_store_o,
    output logic [AmIdxWidth-1:0]        am_ex_addr_o,
    output logic [NumMst-1:0]            am_ex_id_o,
    input  logic                         am_ex_okay_i
`ifdef ACE_CCU_EXCL_STATS_EN
    ,
    output logic [StatWidth-1:0]         stat_st_ok_o,
    output logic [StatWidth-1:0]         stat_st_fail_o
`endif
);

    localparam int unsigned IdxWidth = (NumMst > 1) ? $clog2(NumMst) : 1;

    excl_state_e           state_r, state_nxt_s;
    logic [IdxWidth-1:0]   ptr_r, ptr_nxt_s;
    logic [IdxWidth-1:0]   mst_r;
    excl_op_e              op_r;
    logic [AmIdxWidth-1:0] addr_r;
    logic                  exokay_r;

    mst_idx_t              gnt_s;
    logic [IdxWidth-1:0]   gnt_idx_s;
    logic                  gnt_any_s;
    logic                  accept_s;
    logic                  resp_hs_s;
    logic [AmIdxWidth-1:0] addr_arr_s [NumMst];

    for (genvar g = 0; g < NumMst; g++) begin : g_addr
        assign addr_arr_s[g] = req_addr_i[g*AmIdxWidth +: AmIdxWidth];
    end

    ace_ccu_excl_rr_arb #(
        .NumMst   (NumMst),
        .IdxWidth (IdxWidth)
    ) u_arb (
        .req     (req_valid_i),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    assign ptr_nxt_s = (gnt_idx_s == IdxWidth'(NumMst - 1)) ? '0 : gnt_idx_s + IdxWidth'(1);

    // Next-state and output decode; grants are withheld while reset is asserted.
    always_comb begin
        state_nxt_s   = state_r;
        accept_s      = 1'b0;
        resp_hs_s     = 1'b0;
        req_ready_o   = '0;
        resp_valid_o  = '0;
        resp_exokay_o = 1'b0;
        am_ex_load_o  = 1'b0;
        am_ex_store_o = 1'b0;
        am_ex_addr_o  = '0;
        am_ex_id_o    = '0;
        case (state_r)
            IDLE: begin
                if (gnt_any_s && !rst_i) begin
                    req_ready_o = gnt_s;
                    accept_s    = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                am_ex_load_o  = (op_r == EXCL_LOAD);
                am_ex_store_o = (op_r == EXCL_STORE);
                am_ex_addr_o  = addr_r;
                am_ex_id_o    = mst_idx_t'(1) << mst_r;
                state_nxt_s   = RESP;
            end
            RESP: begin
                resp_valid_o[mst_r] = 1'b1;
                resp_exokay_o       = exokay_r;
                if (resp_ready_i[mst_r]) begin
                    resp_hs_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pointer and transaction registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            mst_r    <= '0;
            op_r     <= EXCL_LOAD;
            addr_r   <= '0;
            exokay_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                ptr_r  <= ptr_nxt_s;
                mst_r  <= gnt_idx_s;
                op_r   <= excl_op_e'(req_store_i[gnt_idx_s]);
                addr_r <= addr_arr_s[gnt_idx_s];
            end
            // Loads are always reported as exclusive-okay regardless of the monitor.
            if (state_r == ISSUE) begin
                exokay_r <= (op_r == EXCL_STORE) ? am_ex_okay_i : 1'b1;
            end
        end
    end

`ifdef ACE_CCU_EXCL_STATS_EN
    logic [StatWidth-1:0] st_ok_r;
    logic [StatWidth-1:0] st_fail_r;

    // Store verdict counters, bumped on the response handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_ok_r   <= '0;
            st_fail_r <= '0;
        end else if (resp_hs_s && (op_r == EXCL_STORE)) begin
            if (exokay_r) begin
                st_ok_r <= sat_inc(st_ok_r);
            end else begin
                st_fail_r <= sat_inc(st_fail_r);
            end
        end
    end

    assign stat_st_ok_o   = st_ok_r;
    assign stat_st_fail_o = st_fail_r;
`endif

endmodule

// File: tb/tb_ace_ccu_excl_requester.sv
// Directed self-checking bench for ace_ccu_excl_requester (stats checks need ACE_CCU_EXCL_STATS_EN).
module tb_ace_ccu_excl_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_store;
    logic [15:0] req_addr;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic        resp_exokay;
    logic        am_load;
    logic        am_store;
    logic [3:0]  am_addr;
    logic [3:0]  am_id;
    logic        am_okay;
`ifdef ACE_CCU_EXCL_STATS_EN
    logic [15:0] st_ok;
    logic [15:0] st_fail;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ace_ccu_excl_requester dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_store_i   (req_store),
        .req_addr_i    (req_addr),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_exokay_o (resp_exokay),
        .am_ex_load_o  (am_load),
        .am_ex_store_o (am_store),
        .am_ex_addr_o  (am_addr),
        .am_ex_id_o    (am_id),
        .am_ex_okay_i  (am_okay)
`ifdef ACE_CCU_EXCL_STATS_EN
        ,
        .stat_st_ok_o   (st_ok),
        .stat_st_fail_o (st_fail)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction from master m, starting and ending in IDLE.
    task automatic do_txn(input int m, input logic st, input logic [3:0] a,
                          input logic ok, input logic exp_ok);
        logic [3:0] oh;
        oh = 4'b0001 << m;
        @(negedge clk);
        req_valid  = oh;
        req_store  = st ? oh : 4'b0000;
        req_addr   = {12'h000, a} << (m * 4);
        am_okay    = ok;
        resp_ready = 4'b0000;
        #1 chk("txn_ready", req_ready, oh);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("txn_load", am_load, !st);
        chk("txn_store", am_store, st);
        chk("txn_id", am_id, oh);
        chk("txn_addr", am_addr, a);
        chk("txn_issue_ready", req_ready, 4'b0000);
        @(negedge clk);
        #1;
        chk("txn_resp_valid", resp_valid, oh);
        chk("txn_exokay", resp_exokay, exp_ok);
        chk("txn_no_pulse", {am_load, am_store}, 2'b00);
        resp_ready = oh;
        @(negedge clk);
        resp_ready = 4'b0000;
        #1 chk("txn_resp_done", resp_valid, 4'b0000);
    endtask

    initial begin
        logic [3:0] oh;
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_store  = 4'b0000;
        req_addr   = 16'h0000;
        resp_ready = 4'b0000;
        am_okay    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_resp_valid", resp_valid, 4'b0000);
        chk("rst_exokay", resp_exokay, 1'b0);
        chk("rst_load", am_load, 1'b0);
        chk("rst_store", am_store, 1'b0);
        chk("rst_addr", am_addr, 4'h0);
        chk("rst_id", am_id, 4'b0000);
        rst = 1'b0;

        // Load ignores a failing monitor verdict; stores pass it through.
        do_txn(2, 1'b0, 4'd5, 1'b0, 1'b1);
        do_txn(1, 1'b1, 4'd3, 1'b1, 1'b1);
        do_txn(1, 1'b1, 4'd3, 1'b0, 1'b0);

        // Round-robin from reset with all masters requesting continuously.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        req_valid  = 4'b1111;
        req_store  = 4'b0000;
        resp_ready = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << (g % 4);
            #1 chk("rr_ready", req_ready, oh);
            @(negedge clk);
            #1 chk("rr_id", am_id, oh);
            @(negedge clk);
            #1 chk("rr_resp", resp_valid, oh);
            @(negedge clk);
        end

        // Backpressure on master 0 with non-granted ready bits high.
        req_valid  = 4'b0000;
        resp_ready = 4'b0000;
        rst        = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0001;
        req_store = 4'b0001;
        req_addr  = 16'h0009;
        am_okay   = 1'b1;
        #1 chk("bp_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("bp_store", am_store, 1'b1);
        chk("bp_addr", am_addr, 4'd9);
        @(negedge clk);
        am_okay    = 1'b0;
        resp_ready = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_valid", resp_valid, 4'b0001);
            chk("bp_exokay", resp_exokay, 1'b1);
            chk("bp_req_ready", req_ready, 4'b0000);
            chk("bp_pulse", {am_load, am_store}, 2'b00);
            @(negedge clk);
        end
        resp_ready = 4'b0001;
        @(negedge clk);
        resp_ready = 4'b0000;
        #1;
        chk("bp_next_ready", req_ready, 4'b0010);
        chk("bp_released", resp_valid, 4'b0000);

        // Reset while master 1 waits in RESP.
        @(negedge clk);
        @(negedge clk);
        #1 chk("mid_resp", resp_valid, 4'b0010);
        rst       = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        chk("mrst_resp_valid", resp_valid, 4'b0000);
        chk("mrst_exokay", resp_exokay, 1'b0);
        chk("mrst_req_ready", req_ready, 4'b0000);
        chk("mrst_load", am_load, 1'b0);
        chk("mrst_store", am_store, 1'b0);
        chk("mrst_addr", am_addr, 4'h0);
        chk("mrst_id", am_id, 4'b0000);
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1 chk("mrst_ptr_zero", req_ready, 4'b0001);
        req_valid = 4'b0000;

`ifdef ACE_CCU_EXCL_STATS_EN
        do_txn(0, 1'b1, 4'd1, 1'b1, 1'b1);
        do_txn(3, 1'b1, 4'd2, 1'b0, 1'b0);
        do_txn(2, 1'b1, 4'd3, 1'b1, 1'b1);
        do_txn(0, 1'b0, 4'd4, 1'b0, 1'b1);
        do_txn(1, 1'b1, 4'd5, 1'b0, 1'b0);
        do_txn(2, 1'b1, 4'd6, 1'b1, 1'b1);
        #1;
        chk("stat_ok", st_ok, 16'd3);
        chk("stat_fail", st_fail, 16'd2);
        force dut.st_ok_r = 16'hFFFF;
        #1;
        release dut.st_ok_r;
        do_txn(3, 1'b1, 4'd7, 1'b1, 1'b1);
        #1;
        chk("stat_ok_sat", st_ok, 16'hFFFF);
        chk("stat_fail_hold", st_fail, 16'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
